// File: rtl/sfp_link_sequencer.sv
// ---------------------------------------------------------------------------
// sfp_link_sequencer
//
// Per-lane bring-up and recovery controller for the 10GBASE-R SFP lanes.
// Each lane walks WAIT_PLL -> REQ -> RST -> WAIT_LOCK -> DEBOUNCE -> UP.
// A single PCS reset slot is shared by all lanes and handed out round-robin,
// so at most one lane is pulsing its PCS reset at any time. Loss of the
// shared QPLL lock sends every lane back to WAIT_PLL.
//
// Ports
//   sysclk_100m     in   system clock, all logic on the rising edge
//   sys_reset       in   synchronous active-high reset
//   qpll_lock       in   shared QPLL lock (already synchronized)
//   pcs_resetdone   in   per-lane PCS/PMA reset done (synchronized)
//   pcs_block_lock  in   per-lane 64b/66b block lock (synchronized)
//   pcs_reset       out  per-lane PCS/PMA reset, high in WAIT_PLL/REQ/RST
//   link_up         out  per-lane, high only in UP
//   retry_cnt       out  per-lane saturating retry count, lane i at [8i+7:8i]
//   slot_busy       out  reset slot currently granted to a lane in RST
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module sfp_link_sequencer #(
    parameter int SFP_COUNT    = 2,
    parameter int RST_CYCLES   = 100,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int UP_DEBOUNCE  = 1000
) (
    input  logic                   sysclk_100m,
    input  logic                   sys_reset,
    input  logic                   qpll_lock,
    input  logic [SFP_COUNT-1:0]   pcs_resetdone,
    input  logic [SFP_COUNT-1:0]   pcs_block_lock,
    output logic [SFP_COUNT-1:0]   pcs_reset,
    output logic [SFP_COUNT-1:0]   link_up,
    output logic [8*SFP_COUNT-1:0] retry_cnt,
    output logic                   slot_busy
);

    // One shared down-counter per lane, wide enough for the longest interval.
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > UP_DEBOUNCE) ? CNT_MAX_A : UP_DEBOUNCE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int PTR_W     = (SFP_COUNT > 1) ? $clog2(SFP_COUNT) : 1;

    // Counters are loaded with N-1 on state entry and the state exits on the
    // cycle the counter reads zero, giving exactly N cycles in the state.
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(UP_DEBOUNCE - 1);

    typedef enum logic [2:0] {
        ST_WAIT_PLL  = 3'd0,
        ST_REQ       = 3'd1,
        ST_RST       = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_DEBOUNCE  = 3'd4,
        ST_UP        = 3'd5
    } state_t;

    state_t                   r_state [SFP_COUNT];
    logic [CNT_W-1:0]         r_cnt   [SFP_COUNT];
    logic [8*SFP_COUNT-1:0]   r_retry_cnt;
    logic [SFP_COUNT-1:0]     r_pcs_reset;
    logic [SFP_COUNT-1:0]     r_link_up;
    logic                     r_slot_busy;
    logic [PTR_W-1:0]         r_rr_ptr;

    logic                     w_grant_valid;
    logic [PTR_W-1:0]         w_grant_idx;
    logic [PTR_W-1:0]         w_scan_idx;
    logic [SFP_COUNT-1:0]     w_rst_stay;
    logic                     w_slot_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round-robin arbiter: scan from the lane after the last grant. A grant
    // is only issued while the slot is free and the QPLL is locked (a QPLL
    // drop overrides any pending grant).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_grant_valid = 1'b0;
        w_grant_idx   = r_rr_ptr;
        w_scan_idx    = r_rr_ptr;
        if (!r_slot_busy && qpll_lock) begin
            for (int k = 1; k <= SFP_COUNT; k++) begin
                w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % SFP_COUNT);
                if (!w_grant_valid && r_state[w_scan_idx] == ST_REQ) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_scan_idx;
                end
            end
        end
    end

    // The slot stays busy while its owner remains in RST next cycle, or when
    // a new grant is being issued this cycle.
    always_comb begin
        w_rst_stay = '0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            w_rst_stay[i] = (r_state[i] == ST_RST) && (r_cnt[i] != '0) && qpll_lock;
        end
        w_slot_next = w_grant_valid | (|w_rst_stay);
    end

    // NOTE: all state and output flops use non-blocking assignments so every
    // lane sees the same pre-edge values regardless of loop order.
    always_ff @(posedge sysclk_100m) begin
        if (sys_reset) begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                r_state[i] <= ST_WAIT_PLL;
                r_cnt[i]   <= '0;
            end
            r_retry_cnt <= '0;
            r_pcs_reset <= '1;
            r_link_up   <= '0;
            r_slot_busy <= 1'b0;
            r_rr_ptr    <= PTR_W'(SFP_COUNT - 1);
        end else begin
            r_slot_busy <= w_slot_next;
            if (w_grant_valid) begin
                r_rr_ptr <= w_grant_idx;
            end

            for (int i = 0; i < SFP_COUNT; i++) begin
                if (!qpll_lock) begin
                    // Global override; a lane in RST implicitly frees the slot.
                    r_state[i]     <= ST_WAIT_PLL;
                    r_pcs_reset[i] <= 1'b1;
                    r_link_up[i]   <= 1'b0;
                end else begin
                    unique case (r_state[i])
                        ST_WAIT_PLL: begin
                            r_state[i] <= ST_REQ;
                        end

                        ST_REQ: begin
                            if (w_grant_valid && w_grant_idx == PTR_W'(i)) begin
                                r_state[i] <= ST_RST;
                                r_cnt[i]   <= RST_LOAD;
                            end
                        end

                        ST_RST: begin
                            if (r_cnt[i] == '0) begin
                                r_state[i]     <= ST_WAIT_LOCK;
                                r_cnt[i]       <= LOCK_LOAD;
                                r_pcs_reset[i] <= 1'b0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - 1'b1;
                            end
                        end

                        ST_WAIT_LOCK: begin
                            // Lock is tested before the timeout so lock wins a tie.
                            if (pcs_resetdone[i] && pcs_block_lock[i]) begin
                                r_state[i] <= ST_DEBOUNCE;
                                r_cnt[i]   <= DEB_LOAD;
                            end else if (r_cnt[i] == '0) begin
                                r_state[i]            <= ST_REQ;
                                r_pcs_reset[i]        <= 1'b1;
                                r_retry_cnt[8*i +: 8] <= sat_inc(r_retry_cnt[8*i +: 8]);
                            end else begin
                                r_cnt[i] <= r_cnt[i] - 1'b1;
                            end
                        end

                        ST_DEBOUNCE: begin
                            // A drop on any cycle, including the last, restarts
                            // the lock wait with a fresh timeout.
                            if (!pcs_block_lock[i]) begin
                                r_state[i] <= ST_WAIT_LOCK;
                                r_cnt[i]   <= LOCK_LOAD;
                            end else if (r_cnt[i] == '0) begin
                                r_state[i]   <= ST_UP;
                                r_link_up[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - 1'b1;
                            end
                        end

                        ST_UP: begin
                            if (!pcs_block_lock[i] || !pcs_resetdone[i]) begin
                                r_state[i]            <= ST_REQ;
                                r_link_up[i]          <= 1'b0;
                                r_pcs_reset[i]        <= 1'b1;
                                r_retry_cnt[8*i +: 8] <= sat_inc(r_retry_cnt[8*i +: 8]);
                            end
                        end

                        default: begin
                            r_state[i]     <= ST_WAIT_PLL;
                            r_pcs_reset[i] <= 1'b1;
                            r_link_up[i]   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign pcs_reset = r_pcs_reset;
    assign link_up   = r_link_up;
    assign retry_cnt = r_retry_cnt;
    assign slot_busy = r_slot_busy;

endmodule

// File: tb/tb_sfp_link_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sfp_link_sequencer
//
// Directed scenarios (serialized bring-up, link drop, debounce glitch, QPLL
// loss in RST, sync reset, timeout saturation) followed by a random soak.
// A behavioural lane model tracks each lane's phase and time-in-phase plus
// the current slot owner, and every cycle all outputs are compared to it.
// The PHY side is emulated: resetdone/block_lock rise a programmable number
// of cycles after the model says the lane's PCS reset was released.
// ---------------------------------------------------------------------------
module tb_sfp_link_sequencer;

    localparam int NL      = 2;
    localparam int RST_C   = 4;
    localparam int LOCK_TO = 50;
    localparam int DEB     = 8;

    // Model phases
    localparam int P_PLL = 0;
    localparam int P_REQ = 1;
    localparam int P_RST = 2;
    localparam int P_WL  = 3;
    localparam int P_DEB = 4;
    localparam int P_UP  = 5;

    logic              clk = 1'b0;
    logic              sys_reset;
    logic              qpll_lock;
    logic [NL-1:0]     resetdone;
    logic [NL-1:0]     block_lock;
    logic [NL-1:0]     pcs_reset;
    logic [NL-1:0]     link_up;
    logic [8*NL-1:0]   retry_cnt;
    logic              slot_busy;

    always #5 clk = ~clk;

    sfp_link_sequencer #(
        .SFP_COUNT    (NL),
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (LOCK_TO),
        .UP_DEBOUNCE  (DEB)
    ) dut (
        .sysclk_100m    (clk),
        .sys_reset      (sys_reset),
        .qpll_lock      (qpll_lock),
        .pcs_resetdone  (resetdone),
        .pcs_block_lock (block_lock),
        .pcs_reset      (pcs_reset),
        .link_up        (link_up),
        .retry_cnt      (retry_cnt),
        .slot_busy      (slot_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model
    int m_phase [NL];
    int m_age   [NL];
    int m_retry [NL];
    int m_owner;
    int m_ptr;

    // PHY emulation
    bit phy_en    [NL];
    int phy_delay [NL];
    int phy_ctr   [NL];
    bit drop      [NL];
    bit rand_delay;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            m_phase[l] = P_PLL;
            m_age[l]   = 0;
            m_retry[l] = 0;
        end
        m_owner = -1;
        m_ptr   = NL - 1;
    endfunction

    function automatic bit in_reset_phase(input int p);
        return (p == P_PLL) || (p == P_REQ) || (p == P_RST);
    endfunction

    // Advance the model by one clock using the inputs applied this cycle.
    function automatic void model_step();
        int win;
        int nxt;
        if (sys_reset) begin
            model_reset();
            return;
        end
        win = -1;
        if (m_owner < 0 && qpll_lock) begin
            for (int k = 1; k <= NL; k++) begin
                int l;
                l = (m_ptr + k) % NL;
                if (win < 0 && m_phase[l] == P_REQ) win = l;
            end
        end
        for (int l = 0; l < NL; l++) begin
            nxt = m_phase[l];
            if (!qpll_lock) begin
                nxt = P_PLL;
            end else begin
                case (m_phase[l])
                    P_PLL: nxt = P_REQ;
                    P_REQ: if (l == win) nxt = P_RST;
                    P_RST: if (m_age[l] + 1 == RST_C) nxt = P_WL;
                    P_WL: begin
                        if (resetdone[l] && block_lock[l]) nxt = P_DEB;
                        else if (m_age[l] + 1 == LOCK_TO) begin
                            nxt = P_REQ;
                            m_retry[l] = (m_retry[l] < 255) ? m_retry[l] + 1 : 255;
                        end
                    end
                    P_DEB: begin
                        if (!block_lock[l]) nxt = P_WL;
                        else if (m_age[l] + 1 == DEB) nxt = P_UP;
                    end
                    P_UP: begin
                        if (!block_lock[l] || !resetdone[l]) begin
                            nxt = P_REQ;
                            m_retry[l] = (m_retry[l] < 255) ? m_retry[l] + 1 : 255;
                        end
                    end
                    default: nxt = P_PLL;
                endcase
            end
            m_age[l]   = (nxt == m_phase[l]) ? m_age[l] + 1 : 0;
            m_phase[l] = nxt;
        end
        if (m_owner >= 0 && m_phase[m_owner] != P_RST) m_owner = -1;
        if (win >= 0) begin
            m_owner = win;
            m_ptr   = win;
        end
    endfunction

    function automatic logic [NL-1:0] exp_pcs();
        logic [NL-1:0] v;
        for (int l = 0; l < NL; l++) v[l] = in_reset_phase(m_phase[l]);
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_up();
        logic [NL-1:0] v;
        for (int l = 0; l < NL; l++) v[l] = (m_phase[l] == P_UP);
        return v;
    endfunction

    function automatic logic [8*NL-1:0] exp_retry();
        logic [8*NL-1:0] v;
        for (int l = 0; l < NL; l++) v[8*l +: 8] = 8'(m_retry[l]);
        return v;
    endfunction

    // PHY responds to the model's view of the PCS reset.
    task automatic drive_phy();
        for (int l = 0; l < NL; l++) begin
            if (in_reset_phase(m_phase[l])) begin
                phy_ctr[l] = 0;
                if (rand_delay) phy_delay[l] = int'($urandom_range(1, 60));
            end else begin
                phy_ctr[l]++;
            end
            resetdone[l]  = phy_en[l] && (phy_ctr[l] > 0) && (phy_ctr[l] >= phy_delay[l]);
            block_lock[l] = resetdone[l] && !drop[l];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("pcs_reset", 32'(pcs_reset), 32'(exp_pcs()));
        check("link_up",   32'(link_up),   32'(exp_up()));
        check("retry_cnt", 32'(retry_cnt), 32'(exp_retry()));
        check("slot_busy", 32'(slot_busy), 32'(m_owner >= 0));
        drive_phy();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pcs"},   32'(pcs_reset), 32'h3);
        check({tag, "_up"},    32'(link_up),   32'h0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'h0);
        check({tag, "_busy"},  32'(slot_busy), 32'h0);
    endtask

    initial begin
        int c0, fall0, fall1, lk0, lk1, up0, up1, g, nrise;
        int rise [3];
        bit armed;
        logic prev;

        sys_reset  = 1'b1;
        qpll_lock  = 1'b0;
        resetdone  = '0;
        block_lock = '0;
        rand_delay = 1'b0;
        for (int l = 0; l < NL; l++) begin
            phy_en[l] = 1'b0; phy_delay[l] = 10; phy_ctr[l] = 0; drop[l] = 1'b0;
        end
        model_reset();

        // ---- reset values ------------------------------------------------
        repeat (3) tick();
        check_reset_values("reset");

        // ---- 1: serialized bring-up ----------------------------------------
        sys_reset = 1'b0;
        for (int l = 0; l < NL; l++) phy_en[l] = 1'b1;
        qpll_lock = 1'b1;
        c0 = cyc;
        fall0 = -1; fall1 = -1; lk0 = -1; lk1 = -1; up0 = -1; up1 = -1;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (fall0 < 0 && pcs_reset[0] === 1'b0) fall0 = cyc;
            if (fall1 < 0 && pcs_reset[1] === 1'b0) fall1 = cyc;
            if (lk0 < 0 && block_lock[0]) lk0 = cyc;
            if (lk1 < 0 && block_lock[1]) lk1 = cyc;
            if (up0 < 0 && link_up[0] === 1'b1) up0 = cyc;
            if (up1 < 0 && link_up[1] === 1'b1) up1 = cyc;
        end
        check("t1_lane0_release", 32'(fall0 - c0), 32'(2 + RST_C));
        check("t1_lane1_release", 32'(fall1 - fall0), 32'(RST_C + 1));
        check("t1_lane0_up_lat", 32'(up0 - lk0), 32'(DEB + 1));
        check("t1_lane1_up_lat", 32'(up1 - lk1), 32'(DEB + 1));
        check("t1_retry", 32'(retry_cnt), 32'h0);

        // ---- 4: link drop in UP on lane 0 ----------------------------------
        drop[0] = 1'b1;
        block_lock[0] = 1'b0;
        tick();
        drop[0] = 1'b0;
        check("t4_link_up0", 32'(link_up[0]), 32'h0);
        check("t4_pcs_reset0", 32'(pcs_reset[0]), 32'h1);
        check("t4_retry0", 32'(retry_cnt[7:0]), 32'h1);

        // ---- 3: debounce glitch on the final DEBOUNCE cycle ----------------
        armed = 1'b1;
        g = -1;
        for (int k = 0; k < 200 && armed; k++) begin
            tick();
            if (m_phase[0] == P_DEB && m_age[0] == DEB - 1) begin
                block_lock[0] = 1'b0;
                armed = 1'b0;
                g = cyc;
            end
        end
        check("t3_glitch_reached", 32'(armed), 32'h0);
        tick();
        check("t3_no_up", 32'(link_up[0]), 32'h0);
        for (int k = 0; k < 100 && link_up[0] !== 1'b1; k++) tick();
        check("t3_up_after_restore", 32'(cyc - g), 32'(DEB + 2));
        check("t3_retry0", 32'(retry_cnt[7:0]), 32'h1);

        // ---- 5: QPLL loss while lane 0 is in RST ---------------------------
        drop[0] = 1'b1;
        block_lock[0] = 1'b0;
        tick();
        drop[0] = 1'b0;
        for (int k = 0; k < 50 && m_phase[0] != P_RST; k++) tick();
        check("t5_busy_in_rst", 32'(slot_busy), 32'h1);
        qpll_lock = 1'b0;
        tick();
        check("t5_pcs", 32'(pcs_reset), 32'h3);
        check("t5_up", 32'(link_up), 32'h0);
        check("t5_busy", 32'(slot_busy), 32'h0);
        check("t5_retry", 32'(retry_cnt), 32'h0002);
        qpll_lock = 1'b1;
        for (int k = 0; k < 400 && link_up !== 2'b11; k++) tick();
        check("t5_both_up", 32'(link_up), 32'h3);

        // ---- 6: sync reset with both links up ------------------------------
        phy_en[1] = 1'b0;
        sys_reset = 1'b1;
        tick();
        check_reset_values("t6_reset");
        sys_reset = 1'b0;
        for (int k = 0; k < 100 && pcs_reset[0] !== 1'b0; k++) tick();
        check("t6_lane0_first", 32'(pcs_reset), 32'h2);

        // ---- 2: lane 1 timeouts, then saturation ---------------------------
        nrise = 0;
        rise[0] = -1000; rise[1] = -1000; rise[2] = -1000;
        prev = pcs_reset[1];
        for (int k = 0; k < 600 && nrise < 3; k++) begin
            tick();
            if (prev === 1'b0 && pcs_reset[1] === 1'b1) begin
                check("t2_retry_step", 32'(retry_cnt[15:8]), 32'(nrise + 1));
                rise[nrise] = cyc;
                nrise++;
            end
            prev = pcs_reset[1];
        end
        check("t2_period_a", 32'(rise[1] - rise[0]), 32'(LOCK_TO + RST_C + 1));
        check("t2_period_b", 32'(rise[2] - rise[1]), 32'(LOCK_TO + RST_C + 1));
        for (int k = 0; k < 16000 && retry_cnt[15:8] !== 8'hFF; k++) tick();
        repeat (120) tick();
        check("t2_saturated", 32'(retry_cnt[15:8]), 32'hFF);
        check("t2_lane0_retry", 32'(retry_cnt[7:0]), 32'h0);
        check("t2_lane0_up", 32'(link_up[0]), 32'h1);

        // ---- random soak ---------------------------------------------------
        phy_en[1] = 1'b1;
        rand_delay = 1'b1;
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            qpll_lock = ($urandom_range(0, 299) != 0);
            sys_reset = ($urandom_range(0, 1999) == 0);
            for (int l = 0; l < NL; l++) begin
                drop[l] = ($urandom_range(0, 149) == 0);
                block_lock[l] = resetdone[l] && !drop[l];
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
